// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: fetches 16-bit instructions into IR, issues them to the controller and tracks retirement.
// Define FETCH_TIMEOUT_EN to halt with fetch_err when mem_ready does not arrive within TIMEOUT_CYC cycles.
module instr_fetch_issue #(
  parameter int PC_W        = 8,
  parameter int RESET_PC    = 0,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_ready,
  output logic            start,
  input  logic            waiting,
  output logic [2:0]      opcode,
  output logic [1:0]      ALU_op,
  output logic [1:0]      shift_op,
  output logic [2:0]      rn,
  output logic [2:0]      rd,
  output logic [2:0]      rm,
  output logic [15:0]     sximm8,
  output logic [15:0]     sximm5,
  output logic            halted,
  output logic            fetch_err
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE, HALT} state_t;
  state_t          state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            retry;
`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
`else
  assign fetch_err = 1'b0;
`endif
  assign mem_addr = pc;
  assign opcode   = ir[15:13];
  assign ALU_op   = ir[12:11];
  assign rn       = ir[10:8];
  assign rd       = ir[7:5];
  assign shift_op = ir[4:3];
  assign rm       = ir[2:0];
  assign sximm8   = {{8{ir[7]}}, ir[7:0]};
  assign sximm5   = {{11{ir[4]}}, ir[4:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= PC_W'(RESET_PC);
      ir     <= '0;
      start  <= 1'b0;
      mem_rd <= 1'b0;
      halted <= 1'b0;
      retry  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tcnt      <= '0;
      fetch_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (run && waiting) begin
          state  <= FETCH;
          mem_rd <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        FETCH: if (mem_ready) begin
          ir     <= mem_rdata;
          mem_rd <= 1'b0;
          if (&mem_rdata[15:13]) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= ISSUE;
            start <= 1'b1;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          state     <= HALT;
          mem_rd    <= 1'b0;
          halted    <= 1'b1;
          fetch_err <= 1'b1;
        end else tcnt <= tcnt + 1'b1;
`endif
        ISSUE: begin
          start <= 1'b0;
          retry <= 1'b0;
          state <= WAIT_BUSY;
        end
        // two idle cycles after start means the controller missed it: issue again
        WAIT_BUSY: if (!waiting) state <= WAIT_DONE;
          else if (retry) begin
            state <= ISSUE;
            start <= 1'b1;
          end else retry <= 1'b1;
        WAIT_DONE: if (waiting) begin
          pc     <= pc + 1'b1;
          state  <= run ? FETCH : IDLE;
          mem_rd <= run;
`ifdef FETCH_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_issue.sv
// tb_instr_fetch_issue: directed checks of fetch, decode, handshake, halt, wrap, reset and timeout behaviour.
module tb_instr_fetch_issue;
  logic        clk = 1'b0;
  logic        rst, run, mem_rd, mem_ready, start, waiting, halted, fetch_err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata, sximm8, sximm5;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  ALU_op, shift_op;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  instr_fetch_issue #(.PC_W(8), .RESET_PC(0), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .start(start), .waiting(waiting),
    .opcode(opcode), .ALU_op(ALU_op), .shift_op(shift_op), .rn(rn), .rd(rd), .rm(rm),
    .sximm8(sximm8), .sximm5(sximm5), .halted(halted), .fetch_err(fetch_err)
  );
  typedef struct {
    logic [15:0] w;
    logic [2:0]  op;
    logic [1:0]  alu;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] s8;
    logic [15:0] s5;
    int          lat;
  } vec_t;
  vec_t vecs [4];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic quick_instr(input logic [15:0] w);
    mem_rdata = w;
    mem_ready = 1'b1;
    step;
    mem_ready = 1'b0;
    step;
    waiting = 1'b0;
    step;
    waiting = 1'b1;
    step;
  endtask
  initial begin
    vecs[0] = '{16'h1234, 3'b000, 2'b10, 3'b010, 3'b001, 2'b10, 3'b100, 16'h0034, 16'hFFF4, 0};
    vecs[1] = '{16'h6F8F, 3'b011, 2'b01, 3'b111, 3'b100, 2'b01, 3'b111, 16'hFF8F, 16'h000F, 2};
    vecs[2] = '{16'hC07F, 3'b110, 2'b00, 3'b000, 3'b011, 2'b11, 3'b111, 16'h007F, 16'hFFFF, 1};
    vecs[3] = '{16'h9880, 3'b100, 2'b11, 3'b000, 3'b100, 2'b00, 3'b000, 16'hFF80, 16'h0000, 3};
    rst = 1'b1; run = 1'b0; waiting = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    step;
    step;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_start", start, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fetch_err", fetch_err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_decode", {opcode, sximm8}, 0);
    rst = 1'b0;
    step;
    chk("idle_hold", mem_rd, 0);
    run = 1'b1;
    step;
    chk("fetch0_rd", mem_rd, 1);
    chk("fetch0_addr", mem_addr, 0);
    mem_rdata = 16'hA1B2;
    mem_ready = 1'b1;
    step;
    mem_ready = 1'b0;
    chk("issue0_start", start, 1);
    chk("issue0_rd", mem_rd, 0);
    chk("issue0_dec", {opcode, ALU_op, rn, rd, rm, shift_op}, {3'b101, 2'b00, 3'b001, 3'b101, 3'b010, 2'b10});
    chk("issue0_sx8", sximm8, 16'hFFB2);
    step;
    chk("wb0_start", start, 0);
    waiting = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      chk("busy0", {start, mem_rd, mem_addr}, 0);
    end
    waiting = 1'b1;
    step;
    chk("retire0_addr", mem_addr, 1);
    chk("retire0_rd", {mem_rd, start}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      chk("tbl_addr", mem_addr, 32'(i + 1));
      for (int j = 0; j < vecs[i].lat; j++) begin
        step;
        chk("tbl_wait_rd", {mem_rd, start}, 2'b10);
      end
      mem_rdata = vecs[i].w;
      mem_ready = 1'b1;
      step;
      mem_ready = 1'b0;
      chk("tbl_start", start, 1);
      chk("tbl_dec", {opcode, ALU_op, rn, rd, rm, shift_op},
          {vecs[i].op, vecs[i].alu, vecs[i].rn, vecs[i].rd, vecs[i].rm, vecs[i].sh});
      chk("tbl_sx8", sximm8, vecs[i].s8);
      chk("tbl_sx5", sximm5, vecs[i].s5);
      step;
      waiting = 1'b0;
      step;
      chk("tbl_ir_stable", {opcode, sximm8}, {vecs[i].op, vecs[i].s8});
      waiting = 1'b1;
      step;
      chk("tbl_next_rd", mem_rd, 1);
    end
    mem_rdata = 16'h1234;
    mem_ready = 1'b1;
    step;
    mem_ready = 1'b0;
    chk("retry_start1", start, 1);
    step;
    chk("retry_wb1", start, 0);
    step;
    chk("retry_wb2", start, 0);
    step;
    chk("retry_start2", start, 1);
    step;
    waiting = 1'b0;
    step;
    chk("retry_done_start", start, 0);
    run = 1'b0;
    waiting = 1'b1;
    step;
    chk("park_rd", mem_rd, 0);
    chk("park_addr", mem_addr, 6);
    step;
    chk("park_hold", mem_rd, 0);
    run = 1'b1;
    step;
    chk("resume_rd", mem_rd, 1);
    chk("resume_addr", mem_addr, 6);
    mem_rdata = 16'h1234;
    mem_ready = 1'b1;
    step;
    mem_ready = 1'b0;
    step;
    waiting = 1'b0;
    rst = 1'b1;
    step;
    chk("midrst_out", {start, mem_rd, mem_addr}, 0);
    chk("midrst_ir", sximm8, 0);
    rst = 1'b0;
    waiting = 1'b1;
    step;
    chk("midrst_refetch", {mem_rd, mem_addr}, 9'h100);
    for (int i = 0; i < 255; i++) quick_instr(16'h0000);
    chk("wrap_pre", mem_addr, 8'hFF);
    quick_instr(16'h2000);
    chk("wrap_post", {mem_rd, mem_addr}, 9'h100);
    for (int i = 0; i < 3; i++) quick_instr(16'h4321);
    chk("halt_pc", mem_addr, 3);
    mem_rdata = 16'hE000;
    mem_ready = 1'b1;
    step;
    chk("halt_enter", {halted, start, mem_rd, mem_addr}, {1'b1, 1'b0, 1'b0, 8'h03});
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      waiting = i[1];
      step;
      chk("halt_hold", {halted, start, mem_rd, mem_addr}, {1'b1, 1'b0, 1'b0, 8'h03});
    end
    mem_ready = 1'b0;
    waiting = 1'b1;
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
    chk("to_fetch", mem_rd, 1);
`ifdef FETCH_TIMEOUT_EN
    repeat (14) step;
    chk("to_before", {mem_rd, fetch_err, halted}, 3'b100);
    step;
    chk("to_after", {mem_rd, fetch_err, halted}, 3'b011);
`else
    repeat (100) step;
    chk("no_timeout", {mem_rd, fetch_err, halted}, 3'b100);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
